// File: rtl/tagged_target_cache.sv
// Banked, direct-mapped branch target cache indexed by a PC/history hash with partial tags.
// Lookups return per-bank hit/target one cycle later; an INIT sweep clears valid bits after reset.
module tagged_target_cache #(
   parameter int unsigned NUM_BANKS  = 4,
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned HIST_BITS  = 10,
   parameter int unsigned TAG_BITS   = 8,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      lookup_en,
   input  logic [31:0]               pc,
   input  logic [HIST_BITS-1:0]      bhr,
   input  logic                      update_en,
   input  logic                      update_inv,
   input  logic [31:0]               update_pc,
   input  logic [31:0]               update_target,
   input  logic [HIST_BITS-1:0]      update_bhr,
   output logic                      ready,
   output logic                      out_valid,
   output logic [NUM_BANKS-1:0]      hit,
   output logic [32*NUM_BANKS-1:0]   target
);

   localparam int unsigned B    = $clog2(NUM_BANKS);
   localparam int unsigned BW   = (B == 0) ? 1 : B;
   localparam int unsigned SETS = 1 << INDEX_BITS;
   localparam int unsigned HLO  = 2 + B;
   localparam int unsigned HHI  = 2 + B + HIST_BITS;

   typedef enum logic {INIT, RUN} state_e;

   state_e                    state_q, state_d;
   logic [INDEX_BITS-1:0]     cnt_q, cnt_d;
   logic                      ready_q, ready_d;
   logic                      out_valid_q, out_valid_d;
   logic [NUM_BANKS-1:0]      hit_q, hit_d;
   logic [32*NUM_BANKS-1:0]   target_q, target_d;

   logic                      valid_q [NUM_BANKS][SETS];
   logic [TAG_BITS-1:0]       tag_q   [NUM_BANKS][SETS];
   logic [31:0]               tgt_q   [NUM_BANKS][SETS];

   logic [HIST_BITS-1:0]      lk_hash_c, up_hash_c;
   logic [INDEX_BITS-1:0]     lk_idx_c, up_idx_c;
   logic [TAG_BITS-1:0]       lk_tag_c, up_tag_c;
   logic [BW-1:0]             up_bank_c;
   logic                      clr_c, wr_c;
   logic                      ent_v_c;
   logic [TAG_BITS-1:0]       ent_tag_c;
   logic [31:0]               ent_tgt_c;
   logic                      unused_ok;

   // Index/tag/bank derivation, identical on lookup and update sides
   assign lk_hash_c = pc[HLO +: HIST_BITS] ^ pc[HHI +: HIST_BITS] ^ bhr;
   assign up_hash_c = update_pc[HLO +: HIST_BITS] ^ update_pc[HHI +: HIST_BITS] ^ update_bhr;
   assign lk_idx_c  = lk_hash_c[INDEX_BITS-1:0];
   assign up_idx_c  = up_hash_c[INDEX_BITS-1:0];
   assign lk_tag_c  = pc[31 -: TAG_BITS];
   assign up_tag_c  = update_pc[31 -: TAG_BITS];
   assign up_bank_c = BW'((update_pc >> 2) & 32'(NUM_BANKS - 1));
   assign unused_ok = ^{pc, update_pc, lk_hash_c, up_hash_c};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      clr_c       = 1'b0;
      wr_c        = 1'b0;
      out_valid_d = 1'b0;
      hit_d       = '0;
      target_d    = '0;
      ent_v_c     = 1'b0;
      ent_tag_c   = '0;
      ent_tgt_c   = '0;
      case (state_q)
         INIT: begin
            clr_c = 1'b1;
            cnt_d = cnt_q + INDEX_BITS'(1);
            if (cnt_q == INDEX_BITS'(SETS - 1)) state_d = RUN;
         end
         RUN: begin
            wr_c = update_en;
            if (lookup_en) begin
               out_valid_d = 1'b1;
               for (int k = 0; k < NUM_BANKS; k++) begin
                  ent_v_c   = valid_q[k][lk_idx_c];
                  ent_tag_c = tag_q[k][lk_idx_c];
                  ent_tgt_c = tgt_q[k][lk_idx_c];
                  // Forward a same-cycle write/invalidate to the same entry
                  if (BYPASS != 0 && update_en && BW'(k) == up_bank_c && up_idx_c == lk_idx_c) begin
                     ent_v_c   = ~update_inv;
                     ent_tag_c = up_tag_c;
                     ent_tgt_c = update_target;
                  end
                  hit_d[k] = ent_v_c && (ent_tag_c == lk_tag_c);
                  target_d[32*k +: 32] = hit_d[k] ? ent_tgt_c : 32'h0;
               end
            end
         end
         default: state_d = INIT;
      endcase
      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         out_valid_q <= 1'b0;
         hit_q       <= '0;
         target_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         hit_q       <= hit_d;
         target_q    <= target_d;
      end
   end

   // Entry storage: sweep clears, updates write or invalidate one bank
   always_ff @(posedge clk) begin
      if (resetn) begin
         if (clr_c) begin
            for (int k = 0; k < NUM_BANKS; k++) valid_q[k][cnt_q] <= 1'b0;
         end
         if (wr_c) begin
            valid_q[up_bank_c][up_idx_c] <= ~update_inv;
            if (!update_inv) begin
               tag_q[up_bank_c][up_idx_c] <= up_tag_c;
               tgt_q[up_bank_c][up_idx_c] <= update_target;
            end
         end
      end
   end

   assign ready     = ready_q;
   assign out_valid = out_valid_q;
   assign hit       = hit_q;
   assign target    = target_q;

endmodule

// File: tb/tb_tagged_target_cache.sv
// Randomized bench for tagged_target_cache against an array-based reference model,
// plus directed scenarios for sweep timing, tag mismatch, bypass and invalidate.
module tb_tagged_target_cache;

   localparam int unsigned NB   = 4;
   localparam int unsigned IB   = 6;
   localparam int unsigned HB   = 10;
   localparam int unsigned TW   = 8;
   localparam int unsigned BYP  = 1;
   localparam int unsigned BSH  = 2;
   localparam int unsigned SETS = 64;

   logic              clk = 1'b0;
   logic              resetn;
   logic              lookup_en;
   logic [31:0]       pc;
   logic [HB-1:0]     bhr;
   logic              update_en;
   logic              update_inv;
   logic [31:0]       update_pc;
   logic [31:0]       update_target;
   logic [HB-1:0]     update_bhr;
   logic              ready;
   logic              out_valid;
   logic [NB-1:0]     hit;
   logic [32*NB-1:0]  target;

   tagged_target_cache #(
      .NUM_BANKS(NB), .INDEX_BITS(IB), .HIST_BITS(HB), .TAG_BITS(TW), .BYPASS(BYP)
   ) dut (
      .clk(clk), .resetn(resetn), .lookup_en(lookup_en), .pc(pc), .bhr(bhr),
      .update_en(update_en), .update_inv(update_inv), .update_pc(update_pc),
      .update_target(update_target), .update_bhr(update_bhr),
      .ready(ready), .out_valid(out_valid), .hit(hit), .target(target)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   // Reference model: one slot per (bank, index); ready after SETS live cycles
   bit            m_v   [NB][SETS];
   logic [TW-1:0] m_tag [NB][SETS];
   logic [31:0]   m_tgt [NB][SETS];
   bit            m_rdy;
   int            m_sweep;
   logic          e_ready, e_valid;
   logic [NB-1:0] e_hit;
   logic [32*NB-1:0] e_tgt;

   function automatic int m_index(input logic [31:0] p, input logic [HB-1:0] h);
      return int'(((p >> (2 + BSH)) ^ (p >> (2 + BSH + HB)) ^ 32'(h)) % SETS);
   endfunction

   function automatic logic [TW-1:0] m_tagof(input logic [31:0] p);
      return TW'(p >> (32 - TW));
   endfunction

   function automatic int m_bank(input logic [31:0] p);
      return int'((p >> 2) % NB);
   endfunction

   task automatic model_edge();
      int li, ui, ub;
      bit h;
      logic [31:0] g;
      e_valid = 1'b0; e_hit = '0; e_tgt = '0;
      if (!resetn) begin
         m_rdy = 0; m_sweep = 0;
         for (int k = 0; k < NB; k++) for (int i = 0; i < SETS; i++) m_v[k][i] = 0;
      end else begin
         li = m_index(pc, bhr);
         ui = m_index(update_pc, update_bhr);
         ub = m_bank(update_pc);
         if (m_rdy && lookup_en) begin
            e_valid = 1'b1;
            for (int k = 0; k < NB; k++) begin
               h = m_v[k][li] && (m_tag[k][li] == m_tagof(pc));
               g = m_tgt[k][li];
               if (BYP != 0 && update_en && k == ub && ui == li) begin
                  h = !update_inv && (m_tagof(update_pc) == m_tagof(pc));
                  g = update_target;
               end
               e_hit[k] = h;
               if (h) e_tgt[32*k +: 32] = g;
            end
         end
         if (m_rdy && update_en) begin
            m_v[ub][ui] = !update_inv;
            if (!update_inv) begin
               m_tag[ub][ui] = m_tagof(update_pc);
               m_tgt[ub][ui] = update_target;
            end
         end
         if (!m_rdy) begin
            m_sweep++;
            if (m_sweep == SETS) m_rdy = 1;
         end
      end
      e_ready = m_rdy;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("ready", 128'(ready), 128'(e_ready));
      check("out_valid", 128'(out_valid), 128'(e_valid));
      check("hit", 128'(hit), 128'(e_hit));
      check("target", 128'(target), 128'(e_tgt));
   endtask

   task automatic idle();
      lookup_en = 1'b0; update_en = 1'b0; update_inv = 1'b0;
   endtask

   task automatic set_lk(input logic [31:0] p, input logic [HB-1:0] h);
      lookup_en = 1'b1; pc = p; bhr = h;
   endtask

   task automatic set_up(input logic [31:0] p, input logic [HB-1:0] h,
                         input logic [31:0] t, input logic inv);
      update_en = 1'b1; update_pc = p; update_bhr = h; update_target = t; update_inv = inv;
   endtask

   function automatic logic [31:0] rand_pc();
      return (32'($urandom_range(0, 1)) << 24) | (32'($urandom_range(0, 7)) << 4)
             | (32'($urandom_range(0, 3)) << 2);
   endfunction

   task automatic random_ops();
      idle();
      if ($urandom_range(0, 1) == 1) set_lk(rand_pc(), HB'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1)
         set_up(rand_pc(), HB'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0);
      if (lookup_en && update_en && $urandom_range(0, 1) == 1) begin
         update_pc = pc; update_bhr = bhr;
      end
   endtask

   task automatic sweep_after_release(input string name);
      for (int i = 0; i < SETS; i++) begin
         random_ops();
         cyc();
         check(name, 128'(ready), 128'(i == SETS - 1));
      end
      idle();
   endtask

   initial begin
      resetn = 1'b0; pc = '0; bhr = '0; update_pc = '0; update_bhr = '0; update_target = '0;
      idle();
      @(negedge clk);
      cyc();
      cyc();
      resetn = 1'b1;
      sweep_after_release("ready_rise");

      // Write then read back in bank 1
      set_up(32'h0000_1004, '0, 32'h0000_2000, 1'b0);
      cyc(); idle();
      set_lk(32'h0000_1004, '0);
      cyc(); idle();
      check("d_hit_bank1", 128'(hit), 128'(4'b0010));
      check("d_tgt_bank1", 128'(target), 128'({32'h0, 32'h0, 32'h0000_2000, 32'h0}));

      // Same index, different tag
      set_lk(32'h0100_1004, '0);
      cyc(); idle();
      check("d_tag_miss_hit", 128'(hit), 128'(4'b0000));
      check("d_tag_miss_tgt", 128'(target), 128'(0));

      // Same-cycle update and lookup on bank 2
      set_up(32'h0000_1008, '0, 32'h0000_3000, 1'b0);
      set_lk(32'h0000_1008, '0);
      cyc(); idle();
      check("d_bypass_hit2", 128'(hit[2]), 128'(BYP != 0));
      check("d_bypass_tgt2", 128'(target[95:64]), 128'((BYP != 0) ? 32'h0000_3000 : 32'h0));

      // Invalidate then lookup
      set_up(32'h0000_1004, '0, 32'h0, 1'b1);
      cyc(); idle();
      set_lk(32'h0000_1004, '0);
      cyc(); idle();
      check("d_inv_hit1", 128'(hit[1]), 128'(0));

      for (int i = 0; i < 3000; i++) begin
         random_ops();
         cyc();
      end
      idle();

      // Rewrite a known entry, then reset mid-sweep
      set_up(32'h0000_1008, '0, 32'h0000_3000, 1'b0);
      cyc(); idle();
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      for (int i = 0; i < 30; i++) begin
         random_ops();
         cyc();
         check("sweep_ready_low", 128'(ready), 128'(0));
      end
      idle();
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      sweep_after_release("ready_rise_restart");
      set_lk(32'h0000_1008, '0);
      cyc(); idle();
      check("d_post_reset_valid", 128'(out_valid), 128'(1));
      check("d_post_reset_miss", 128'(hit), 128'(0));

      for (int i = 0; i < 500; i++) begin
         random_ops();
         cyc();
      end
      idle();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
